psum_quant_pack: RTL and testbench

//   Output stage directly downstream of the 3x3 row psum accumulator. Consumes its
//   un-backpressured (result_valid, result) stream of final 32-bit output-channel sums.
//   Per element: adds bias, applies optional ReLU, right-shifts with rounding, and

---
 rtl/ru_quant_pkg.sv | 20 ++
 rtl/psum_quant_pack_if.sv | 25 ++
 rtl/qpk_word_fifo.sv | 42 ++++
 rtl/psum_quant_pack.sv | 101 ++++++++++
 tb/tb_psum_quant_pack.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/ru_quant_pkg.sv
// ru_quant_pkg: shared widths, saturation bounds and per-element config for the psum quantizer
package ru_quant_pkg;
   localparam int DWIDTH = 32;
   localparam int QWIDTH = 8;
   localparam int PACK   = 4;
   localparam int SWIDTH = 5;
   localparam int QMAX   = 2**(QWIDTH-1) - 1;
   localparam int QMIN   = -(2**(QWIDTH-1));

   typedef struct packed {
      logic signed [DWIDTH-1:0] bias;
      logic [SWIDTH-1:0]        shift;
      logic                     relu;
   } cfg_t;

   function automatic logic [QWIDTH-1:0] sat_q(input logic signed [DWIDTH+1:0] y);
      return (y > (DWIDTH+2)'(QMAX)) ? QWIDTH'(QMAX) :
             (y < (DWIDTH+2)'(QMIN)) ? QWIDTH'(QMIN) : y[QWIDTH-1:0];
   endfunction
endpackage

// File: rtl/psum_quant_pack_if.sv
// psum_quant_pack_if: sum stream in, config, and packed-word valid/ready stream out
interface psum_quant_pack_if;
   import ru_quant_pkg::*;
   logic                     result_valid;
   logic [DWIDTH-1:0]        result;
   logic                     flush;
   logic                     cfg_load;
   logic [DWIDTH-1:0]        cfg_bias;
   logic [SWIDTH-1:0]        cfg_shift;
   logic                     cfg_relu;
   logic                     out_valid;
   logic                     out_ready;
   logic [QWIDTH*PACK-1:0]   out_data;
   logic [PACK-1:0]          out_keep;
   logic                     overflow;

   modport master (
      output result_valid, result, flush, cfg_load, cfg_bias, cfg_shift, cfg_relu, out_ready,
      input  out_valid, out_data, out_keep, overflow
   );
   modport slave (
      input  result_valid, result, flush, cfg_load, cfg_bias, cfg_shift, cfg_relu, out_ready,
      output out_valid, out_data, out_keep, overflow
   );
endinterface

// File: rtl/qpk_word_fifo.sv
// qpk_word_fifo: first-word-fall-through word FIFO with sticky drop flag
module qpk_word_fifo #(
   parameter int WIDTH  = 36,
   parameter int AWIDTH = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] wdata,
   input  logic             ready,
   output logic             valid,
   output logic [WIDTH-1:0] rdata,
   output logic             overflow
);
   localparam int DEPTH = 2**AWIDTH;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AWIDTH:0]  wptr, rptr;
   logic             full, pop, wr;

   assign valid = wptr != rptr;
   assign full  = (wptr ^ rptr) == {1'b1, {AWIDTH{1'b0}}};
   assign pop   = valid & ready;
   assign wr    = push & (~full | pop);
   assign rdata = mem[rptr[AWIDTH-1:0]];

   // pointers advance on accepted push/pop; a refused push latches overflow
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         wptr     <= '0;
         rptr     <= '0;
         overflow <= 1'b0;
      end else begin
         wptr     <= wptr + (AWIDTH+1)'(wr);
         rptr     <= rptr + (AWIDTH+1)'(pop);
         overflow <= overflow | (push & ~wr);
      end

   // storage holds no state that matters after reset, so it is left unreset
   always_ff @(posedge clk)
      if (wr) mem[wptr[AWIDTH-1:0]] <= wdata;
endmodule

// File: rtl/psum_quant_pack.sv
// psum_quant_pack: bias, ReLU, rounding shift and saturation of psums, packed into a word FIFO
module psum_quant_pack
   import ru_quant_pkg::*;
#(
   parameter int AWIDTH = 3
) (
   input logic             clk,
   input logic             rst,
   psum_quant_pack_if.slave bus
);
   localparam int LW = $clog2(PACK);
   localparam int WW = QWIDTH*PACK + PACK;

   cfg_t                            cfg_q, cfg1;
   logic                            v1, f1, v2, f2;
   logic signed [DWIDTH:0]          b1;
   logic signed [DWIDTH+1:0]        r2, rnd, y2;
   logic [QWIDTH-1:0]               q2;
   logic [LW-1:0]                   lane_cnt;
   logic [PACK-1:0][QWIDTH-1:0]     lane_q, lane_d;
   logic [PACK-1:0]                 keep_q, keep_d;
   logic                            done, push;
   logic [WW-1:0]                   rdata;

   // live config; each element snapshots it as it enters S1
   always_ff @(posedge clk or posedge rst)
      if (rst) cfg_q <= '0;
      else if (bus.cfg_load) cfg_q <= {bus.cfg_bias, bus.cfg_shift, bus.cfg_relu};

   // S1: widened bias add so extreme sums cannot wrap
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         v1   <= 1'b0;
         f1   <= 1'b0;
         b1   <= '0;
         cfg1 <= '0;
      end else begin
         v1   <= bus.result_valid;
         f1   <= bus.flush;
         b1   <= $signed({bus.result[DWIDTH-1], bus.result}) + $signed({cfg_q.bias[DWIDTH-1], cfg_q.bias});
         cfg1 <= cfg_q;
      end

   assign r2  = (cfg1.relu && b1[DWIDTH]) ? '0 : (DWIDTH+2)'(b1);
   assign rnd = (DWIDTH+2)'(1) << (cfg1.shift - SWIDTH'(1));
   assign y2  = (cfg1.shift != '0) ? (r2 + rnd) >>> cfg1.shift : r2;

   // S2: ReLU, round-half-up shift, saturate
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         v2 <= 1'b0;
         f2 <= 1'b0;
         q2 <= '0;
      end else begin
         v2 <= v1;
         f2 <= f1;
         q2 <= sat_q(y2);
      end

   // merge the incoming lane into the staging word before deciding to push
   always_comb begin
      lane_d = lane_q;
      keep_d = keep_q;
      if (v2) begin
         lane_d[lane_cnt] = q2;
         keep_d[lane_cnt] = 1'b1;
      end
   end

   assign done = v2 && (lane_cnt == LW'(PACK-1));
   assign push = done || (f2 && |keep_d);

   // staging register and lane counter restart after every pushed word
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         lane_q   <= '0;
         keep_q   <= '0;
         lane_cnt <= '0;
      end else if (push) begin
         lane_q   <= '0;
         keep_q   <= '0;
         lane_cnt <= '0;
      end else begin
         lane_q   <= lane_d;
         keep_q   <= keep_d;
         lane_cnt <= lane_cnt + LW'(v2);
      end

   qpk_word_fifo #(.WIDTH(WW), .AWIDTH(AWIDTH)) u_fifo (
      .clk      (clk),
      .rst      (rst),
      .push     (push),
      .wdata    ({keep_d, lane_d}),
      .ready    (bus.out_ready),
      .valid    (bus.out_valid),
      .rdata    (rdata),
      .overflow (bus.overflow)
   );

   assign {bus.out_keep, bus.out_data} = rdata;
endmodule

// File: tb/tb_psum_quant_pack.sv
// tb_psum_quant_pack: directed vectors against a queue-based behavioural model plus literal expectations
module tb_psum_quant_pack;
   import ru_quant_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   psum_quant_pack_if bus();

   psum_quant_pack #(.AWIDTH(3)) dut (.clk(clk), .rst(rst), .bus(bus));

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %h want %h", name, act, exp);
      end
   endtask

   function automatic logic [7:0] quant(input longint r, input longint b, input int s, input bit rl);
      longint x;
      x = r + b;
      if (rl && x < 0) x = 0;
      if (s > 0) x = (x + (longint'(1) << (s - 1))) >>> s;
      if (x > 127) x = 127;
      if (x < -128) x = -128;
      return 8'(x);
   endfunction

   typedef struct { bit v; bit f; logic [7:0] q; } elem_t;
   typedef struct { logic [31:0] d; logic [3:0] k; } word_t;

   elem_t       sr [2];
   elem_t       o;
   logic [7:0]  pend [$];
   word_t       mq [$];
   word_t       w;
   bit          ovf;
   longint      cb;
   int          cs;
   bit          cr;

   // model: two-stage delay, lane gathering, and an 8-deep queue that drops when full
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         mq.delete();
         pend.delete();
         ovf = 0;
         sr[0] = '{0, 0, 8'h0};
         sr[1] = '{0, 0, 8'h0};
         cb = 0;
         cs = 0;
         cr = 0;
      end else begin
         o = sr[1];
         sr[1] = sr[0];
         sr[0].v = bus.result_valid;
         sr[0].f = bus.flush;
         sr[0].q = quant(longint'($signed(bus.result)), cb, cs, cr);
         if (bus.cfg_load) begin
            cb = longint'($signed(bus.cfg_bias));
            cs = int'(bus.cfg_shift);
            cr = bus.cfg_relu;
         end
         if (mq.size() > 0 && bus.out_ready) void'(mq.pop_front());
         if (o.v) pend.push_back(o.q);
         if (pend.size() == 4 || (o.f && pend.size() > 0)) begin
            w.d = '0;
            w.k = '0;
            foreach (pend[i]) begin
               w.d[8*i +: 8] = pend[i];
               w.k[i] = 1'b1;
            end
            pend.delete();
            if (mq.size() < 8) mq.push_back(w);
            else ovf = 1;
         end
      end
   end

   // compare DUT against the model every cycle, away from the active edge
   always @(negedge clk)
      if (!rst) begin
         chk("cmp_valid", 64'(bus.out_valid), 64'(mq.size() > 0));
         if (mq.size() > 0) chk("cmp_word", 64'({bus.out_keep, bus.out_data}), 64'({mq[0].k, mq[0].d}));
         chk("cmp_ovf", 64'(bus.overflow), 64'(ovf));
      end

   task automatic cyc(input bit v, input logic [31:0] r, input bit f);
      bus.result_valid = v;
      bus.result = r;
      bus.flush = f;
      @(posedge clk);
      #1;
      bus.result_valid = 1'b0;
      bus.flush = 1'b0;
      bus.cfg_load = 1'b0;
   endtask

   task automatic load(input logic [31:0] b, input logic [4:0] s, input bit rl);
      bus.cfg_load = 1'b1;
      bus.cfg_bias = b;
      bus.cfg_shift = s;
      bus.cfg_relu = rl;
      cyc(0, 0, 0);
   endtask

   task automatic idle(input int n);
      repeat (n) cyc(0, 0, 0);
   endtask

   int n;

   initial begin
      bus.result_valid = 0;
      bus.result = 0;
      bus.flush = 0;
      bus.cfg_load = 0;
      bus.cfg_bias = 0;
      bus.cfg_shift = 0;
      bus.cfg_relu = 0;
      bus.out_ready = 1;
      repeat (2) @(posedge clk);
      #1 rst = 0;
      chk("rst_valid", 64'(bus.out_valid), 64'd0);
      chk("rst_ovf", 64'(bus.overflow), 64'd0);

      for (int i = 1; i <= 4; i++) cyc(1, 32'(i), 0);
      cyc(0, 0, 0);
      chk("t1_early", 64'(bus.out_valid), 64'd0);
      cyc(0, 0, 0);
      chk("t1_valid", 64'(bus.out_valid), 64'd1);
      chk("t1_data", 64'(bus.out_data), 64'h04030201);
      chk("t1_keep", 64'(bus.out_keep), 64'hf);

      load(-32'sd100, 5'd2, 1'b1);
      cyc(1, 32'd100, 0);
      cyc(1, 32'd101, 0);
      cyc(1, 32'd102, 0);
      cyc(1, 32'd50, 0);
      idle(2);
      chk("t2_data", 64'(bus.out_data), 64'h00010000);

      load(32'd1, 5'd0, 1'b0);
      cyc(1, 32'h7fffffff, 0);
      load(32'd0, 5'd0, 1'b0);
      cyc(1, -32'sd1000, 0);
      load(32'd0, 5'd2, 1'b0);
      cyc(1, 32'd6, 0);
      cyc(1, -32'sd6, 0);
      idle(2);
      chk("t3_data", 64'(bus.out_data), 64'hff02807f);

      load(32'd0, 5'd0, 1'b0);
      cyc(1, 32'd5, 0);
      cyc(1, 32'd6, 0);
      cyc(1, 32'd7, 1);
      idle(2);
      chk("t4_data", 64'(bus.out_data), 64'h00070605);
      chk("t4_keep", 64'(bus.out_keep), 64'h7);
      cyc(0, 0, 1);
      repeat (4) begin
         chk("t4_noword", 64'(bus.out_valid), 64'd0);
         cyc(0, 0, 0);
      end

      bus.out_ready = 0;
      for (int k = 0; k < 9; k++)
         for (int i = 0; i < 4; i++) cyc(1, 32'(4*k + i), 0);
      idle(3);
      chk("t5_ovf", 64'(bus.overflow), 64'd1);
      chk("t5_valid", 64'(bus.out_valid), 64'd1);
      bus.out_ready = 1;
      n = 0;
      for (int c = 0; c < 30 && n < 8; c++) begin
         if (bus.out_valid) begin
            chk("t5_word", 64'(bus.out_data),
                64'({8'(4*n+3), 8'(4*n+2), 8'(4*n+1), 8'(4*n)}));
            n++;
         end
         cyc(0, 0, 0);
      end
      chk("t5_count", 64'(n), 64'd8);
      chk("t5_empty", 64'(bus.out_valid), 64'd0);

      cyc(1, 32'd40, 0);
      load(32'd0, 5'd4, 1'b0);
      cyc(1, 32'd40, 1);
      idle(2);
      chk("t6_data", 64'(bus.out_data), 64'h00000328);
      chk("t6_keep", 64'(bus.out_keep), 64'h3);
      cyc(0, 0, 0);
      cyc(1, 32'd9, 0);
      cyc(1, 32'd9, 0);
      rst = 1;
      idle(2);
      rst = 0;
      chk("t6_rst_valid", 64'(bus.out_valid), 64'd0);
      chk("t6_rst_ovf", 64'(bus.overflow), 64'd0);
      for (int i = 1; i <= 4; i++) cyc(1, 32'(i), 0);
      idle(2);
      chk("t6_after_rst", 64'(bus.out_data), 64'h04030201);
      chk("t6_after_keep", 64'(bus.out_keep), 64'hf);

      idle(3);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
